// File: rtl/mips_rf_pkg.sv
// Shared constants and types for the Mini-MIPS banked register file.
package mips_rf_pkg;

   // Defaults shared with the decode stage
   localparam int unsigned RF_WIDTH  = 32;
   localparam int unsigned RF_DEPTH  = 32;
   localparam int unsigned RF_NBANKS = 2;

   // Bank indices
   localparam int unsigned BANK_GPR = 0;
   localparam int unsigned BANK_FPR = 1;

   typedef enum logic [0:0] {
      RF_IDLE,
      RF_CLEAR
   } rf_state_e;

   // Index width for n entries, never narrower than one bit
   function automatic int unsigned rf_clog2_min1(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mips_rf_bank.sv
// One register bank: single write port, two combinational read taps.
module mips_rf_bank #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 32,
   parameter int unsigned AW    = 5
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    ra_addr,
   input  logic [AW-1:0]    rb_addr,
   output logic [WIDTH-1:0] ra_data_c,
   output logic [WIDTH-1:0] rb_data_c
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Storage write; contents are zeroed by the clear engine, not by reset
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign ra_data_c = mem_q[ra_addr];
   assign rb_data_c = mem_q[rb_addr];

endmodule

// File: rtl/mips_regfile_banked.sv
// Banked architectural register file with self-clearing engine,
// write-first bypass and registered dual read ports.
module mips_regfile_banked
   import mips_rf_pkg::*;
#(
   parameter int unsigned WIDTH     = RF_WIDTH,
   parameter int unsigned DEPTH     = RF_DEPTH,
   parameter int unsigned NBANKS    = RF_NBANKS,
   parameter int unsigned ZERO_REG0 = 1,
   localparam int unsigned AW       = rf_clog2_min1(DEPTH),
   localparam int unsigned BW       = rf_clog2_min1(NBANKS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_req,
   output logic             busy,
   input  logic             we,
   input  logic [BW-1:0]    wbank,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   output logic             wr_drop,
   input  logic             re,
   input  logic [BW-1:0]    ra_bank,
   input  logic [AW-1:0]    ra_addr,
   input  logic [BW-1:0]    rb_bank,
   input  logic [AW-1:0]    rb_addr,
   output logic [WIDTH-1:0] ra_data,
   output logic [WIDTH-1:0] rb_data,
   output logic             rd_valid
);

   rf_state_e        state_q, state_d;
   logic [AW-1:0]    clr_ptr_q, clr_ptr_d;
   logic             busy_q, busy_d;
   logic             wr_drop_q, wr_drop_d;
   logic             rd_valid_q, rd_valid_d;
   logic [WIDTH-1:0] ra_data_q, ra_data_d;
   logic [WIDTH-1:0] rb_data_q, rb_data_d;

   logic              wr_ok_c;
   logic [NBANKS-1:0] bank_we_c;
   logic [AW-1:0]     bank_waddr_c;
   logic [WIDTH-1:0]  bank_wdata_c;
   logic [WIDTH-1:0]  bank_ra_c [NBANKS];
   logic [WIDTH-1:0]  bank_rb_c [NBANKS];

   function automatic logic rf_in_range(input logic [BW-1:0] bank, input logic [AW-1:0] addr);
      return ({1'b0, bank} < (BW+1)'(NBANKS)) && ({1'b0, addr} < (AW+1)'(DEPTH));
   endfunction

   function automatic logic rf_is_zero(input logic [BW-1:0] bank, input logic [AW-1:0] addr);
      return (ZERO_REG0 != 0) && (bank == BW'(BANK_GPR)) && (addr == '0);
   endfunction

   // Clear engine: sweep every entry once, then return to idle
   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      case (state_q)
         RF_IDLE: begin
            if (clr_req) begin
               state_d   = RF_CLEAR;
               clr_ptr_d = '0;
            end
         end
         RF_CLEAR: begin
            if (clr_ptr_q == AW'(DEPTH - 1)) begin
               state_d   = RF_IDLE;
               clr_ptr_d = '0;
            end else begin
               clr_ptr_d = clr_ptr_q + AW'(1);
            end
         end
         default: begin
            state_d   = RF_CLEAR;
            clr_ptr_d = '0;
         end
      endcase
      busy_d = (state_d == RF_CLEAR);
   end

   // Write steering (clear has the port while busy) and read mux with bypass
   always_comb begin
      bank_we_c    = '0;
      wr_ok_c      = we & ~busy_q & rf_in_range(wbank, waddr) & ~rf_is_zero(wbank, waddr);
      bank_waddr_c = busy_q ? clr_ptr_q : waddr;
      bank_wdata_c = busy_q ? '0 : wdata;
      for (int b = 0; b < NBANKS; b++) begin
         bank_we_c[b] = busy_q | (wr_ok_c & (wbank == BW'(b)));
      end

      wr_drop_d  = we & busy_q;
      rd_valid_d = re;
      ra_data_d  = ra_data_q;
      rb_data_d  = rb_data_q;
      if (re) begin
         if (busy_q || !rf_in_range(ra_bank, ra_addr) || rf_is_zero(ra_bank, ra_addr)) begin
            ra_data_d = '0;
         end else if (wr_ok_c && (wbank == ra_bank) && (waddr == ra_addr)) begin
            ra_data_d = wdata;
         end else begin
            ra_data_d = bank_ra_c[ra_bank];
         end
         if (busy_q || !rf_in_range(rb_bank, rb_addr) || rf_is_zero(rb_bank, rb_addr)) begin
            rb_data_d = '0;
         end else if (wr_ok_c && (wbank == rb_bank) && (waddr == rb_addr)) begin
            rb_data_d = wdata;
         end else begin
            rb_data_d = bank_rb_c[rb_bank];
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RF_CLEAR;
         clr_ptr_q  <= '0;
         busy_q     <= 1'b1;
         wr_drop_q  <= 1'b0;
         rd_valid_q <= 1'b0;
         ra_data_q  <= '0;
         rb_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         clr_ptr_q  <= clr_ptr_d;
         busy_q     <= busy_d;
         wr_drop_q  <= wr_drop_d;
         rd_valid_q <= rd_valid_d;
         ra_data_q  <= ra_data_d;
         rb_data_q  <= rb_data_d;
      end
   end

   for (genvar g = 0; g < NBANKS; g++) begin : g_bank
      mips_rf_bank #(
         .WIDTH (WIDTH),
         .DEPTH (DEPTH),
         .AW    (AW)
      ) u_bank (
         .clk       (clk),
         .we        (bank_we_c[g]),
         .waddr     (bank_waddr_c),
         .wdata     (bank_wdata_c),
         .ra_addr   (ra_addr),
         .rb_addr   (rb_addr),
         .ra_data_c (bank_ra_c[g]),
         .rb_data_c (bank_rb_c[g])
      );
   end

   assign busy     = busy_q;
   assign wr_drop  = wr_drop_q;
   assign rd_valid = rd_valid_q;
   assign ra_data  = ra_data_q;
   assign rb_data  = rb_data_q;

endmodule

// File: tb/tb_mips_regfile_banked.sv
// Self-checking bench for mips_regfile_banked: directed vectors, clear and
// reset corner sequences, and random traffic against a behavioural model.
module tb_mips_regfile_banked;
   import mips_rf_pkg::*;

   localparam int NB = 2;
   localparam int D  = 32;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clr_req = 1'b0;
   logic        busy;
   logic        we = 1'b0;
   logic [0:0]  wbank = '0;
   logic [4:0]  waddr = '0;
   logic [31:0] wdata = '0;
   logic        wr_drop;
   logic        re = 1'b0;
   logic [0:0]  ra_bank = '0;
   logic [4:0]  ra_addr = '0;
   logic [0:0]  rb_bank = '0;
   logic [4:0]  rb_addr = '0;
   logic [31:0] ra_data, rb_data;
   logic        rd_valid;

   always #5 clk = ~clk;

   mips_regfile_banked dut (
      .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy),
      .we(we), .wbank(wbank), .waddr(waddr), .wdata(wdata), .wr_drop(wr_drop),
      .re(re), .ra_bank(ra_bank), .ra_addr(ra_addr), .rb_bank(rb_bank), .rb_addr(rb_addr),
      .ra_data(ra_data), .rb_data(rb_data), .rd_valid(rd_valid)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: architectural contents plus remaining busy cycles
   logic [31:0] mem_m [NB][D];
   int          busy_left;
   logic [31:0] e_ra, e_rb;
   logic        e_valid, e_drop;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      foreach (mem_m[b, a]) mem_m[b][a] = '0;
      busy_left = D;
      e_ra = '0; e_rb = '0; e_valid = 1'b0; e_drop = 1'b0;
   endtask

   function automatic logic [31:0] m_read(input int bank, input int addr, input bit busy_now, input bit wr_ok);
      if (busy_now) return '0;
      if (bank >= NB || addr >= D) return '0;
      if (bank == 0 && addr == 0) return '0;
      if (wr_ok && int'(wbank) == bank && int'(waddr) == addr) return wdata;
      return mem_m[bank][addr];
   endfunction

   // Advance the model by one clock edge using the currently driven inputs
   task automatic model_edge();
      bit busy_now;
      bit wr_ok;
      busy_now = (busy_left > 0);
      wr_ok    = we && !busy_now && !(wbank == 1'b0 && waddr == 5'd0);
      e_valid  = re;
      e_drop   = we && busy_now;
      if (re) begin
         e_ra = m_read(int'(ra_bank), int'(ra_addr), busy_now, wr_ok);
         e_rb = m_read(int'(rb_bank), int'(rb_addr), busy_now, wr_ok);
      end
      if (wr_ok) mem_m[wbank][waddr] = wdata;
      if (busy_now) begin
         busy_left--;
      end else if (clr_req) begin
         busy_left = D;
         foreach (mem_m[b, a]) mem_m[b][a] = '0;
      end
   endtask

   task automatic check_all(input string tag);
      chk($sformatf("%s.ra_data", tag), ra_data, e_ra);
      chk($sformatf("%s.rb_data", tag), rb_data, e_rb);
      chk($sformatf("%s.rd_valid", tag), 32'(rd_valid), 32'(e_valid));
      chk($sformatf("%s.wr_drop", tag), 32'(wr_drop), 32'(e_drop));
      chk($sformatf("%s.busy", tag), 32'(busy), 32'(busy_left > 0));
   endtask

   task automatic step(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic set_idle();
      clr_req = 1'b0; we = 1'b0; re = 1'b0;
      wbank = '0; waddr = '0; wdata = '0;
      ra_bank = '0; ra_addr = '0; rb_bank = '0; rb_addr = '0;
   endtask

   task automatic set_rd(input logic [0:0] ab, input logic [4:0] aa, input logic [0:0] bb, input logic [4:0] ba);
      re = 1'b1; ra_bank = ab; ra_addr = aa; rb_bank = bb; rb_addr = ba;
   endtask

   // Step until busy drops; returns the number of cycles busy was seen high
   task automatic count_busy(input string tag, output int n);
      n = 0;
      while (busy && n < 100) begin
         step(tag);
         n++;
      end
   endtask

   typedef struct {
      logic        we;
      logic [0:0]  wbank;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        re;
      logic [0:0]  ra_bank;
      logic [4:0]  ra_addr;
      logic [0:0]  rb_bank;
      logic [4:0]  rb_addr;
      logic [31:0] x_ra;
      logic [31:0] x_rb;
      logic        x_valid;
      logic        x_drop;
   } vec_t;

   vec_t vt [11];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      // Directed vectors, applied back to back after the power-up clear
      vt[0]  = '{1, 0,  7, 32'hDEADBEEF, 0, 0,  0, 0,  0, 32'h0,        32'h0,        0, 0};
      vt[1]  = '{0, 0,  0, 32'h0,        1, 0,  7, 1,  7, 32'hDEADBEEF, 32'h0,        1, 0};
      vt[2]  = '{1, 1,  3, 32'h3F800000, 1, 1,  3, 0,  7, 32'h3F800000, 32'hDEADBEEF, 1, 0};
      vt[3]  = '{1, 0,  0, 32'h12345678, 1, 0,  0, 1,  3, 32'h0,        32'h3F800000, 1, 0};
      vt[4]  = '{0, 0,  0, 32'h0,        1, 0,  0, 0,  5, 32'h0,        32'h0,        1, 0};
      vt[5]  = '{0, 0,  0, 32'h0,        1, 1, 31, 0,  7, 32'h0,        32'hDEADBEEF, 1, 0};
      vt[6]  = '{0, 0,  0, 32'h0,        0, 0,  0, 0,  0, 32'h0,        32'hDEADBEEF, 0, 0};
      vt[7]  = '{1, 0,  1, 32'h1,        1, 0,  1, 0,  1, 32'h1,        32'h1,        1, 0};
      vt[8]  = '{1, 0,  2, 32'h2,        0, 0,  0, 0,  0, 32'h1,        32'h1,        0, 0};
      vt[9]  = '{1, 0,  3, 32'h3,        0, 0,  0, 0,  0, 32'h1,        32'h1,        0, 0};
      vt[10] = '{1, 0,  4, 32'h4,        1, 0,  2, 0,  4, 32'h2,        32'h4,        1, 0};

      // Power-up: reset held, then the clear sweep
      set_idle();
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("in_reset");
      rst_n = 1'b1;
      count_busy("powerup", n);
      chk("powerup_busy_cycles", 32'(n), 32'd32);

      set_rd(0, 5, 1, 31);
      step("rd_after_clear");
      chk("gpr5_after_clear", ra_data, 32'h0);
      chk("fpr31_after_clear", rb_data, 32'h0);
      set_idle();

      for (int i = 0; i < 11; i++) begin
         we = vt[i].we; wbank = vt[i].wbank; waddr = vt[i].waddr; wdata = vt[i].wdata;
         re = vt[i].re; ra_bank = vt[i].ra_bank; ra_addr = vt[i].ra_addr;
         rb_bank = vt[i].rb_bank; rb_addr = vt[i].rb_addr;
         step($sformatf("vec%0d", i));
         chk($sformatf("vec%0d.tbl_ra", i), ra_data, vt[i].x_ra);
         chk($sformatf("vec%0d.tbl_rb", i), rb_data, vt[i].x_rb);
         chk($sformatf("vec%0d.tbl_valid", i), 32'(rd_valid), 32'(vt[i].x_valid));
         chk($sformatf("vec%0d.tbl_drop", i), 32'(wr_drop), 32'(vt[i].x_drop));
      end
      set_idle();

      // Requested clear: write while busy is dropped, a second request is ignored
      clr_req = 1'b1;
      step("clr_req");
      clr_req = 1'b0;
      n = busy ? 1 : 0;
      we = 1'b1; wbank = 0; waddr = 5'd2; wdata = 32'd9;
      step("busy_write");
      chk("busy_write_drop", 32'(wr_drop), 32'd1);
      if (busy) n++;
      set_idle();
      for (int g = 0; g < 100 && busy; g++) begin
         clr_req = (g == 5);
         step("clearing");
         if (busy) n++;
      end
      clr_req = 1'b0;
      chk("clr_busy_cycles", 32'(n), 32'd32);
      set_rd(0, 1, 0, 2);
      step("rd_cleared_a");
      chk("gpr1_cleared", ra_data, 32'h0);
      chk("gpr2_cleared", rb_data, 32'h0);
      set_rd(0, 3, 0, 4);
      step("rd_cleared_b");
      chk("gpr3_cleared", ra_data, 32'h0);
      chk("gpr4_cleared", rb_data, 32'h0);
      chk("drop_cleared", 32'(wr_drop), 32'd0);
      set_idle();

      // Reset in the middle of a clear restarts the full sweep
      we = 1'b1; waddr = 5'd9; wdata = 32'hA5A50001;
      set_rd(0, 9, 0, 9);
      step("pre_reset_wr");
      chk("pre_reset_bypass", ra_data, 32'hA5A50001);
      set_idle();
      clr_req = 1'b1;
      step("clr_req2");
      clr_req = 1'b0;
      repeat (9) step("clear_pre_reset");
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_ra", ra_data, 32'h0);
      chk("rst_rb", rb_data, 32'h0);
      chk("rst_valid", 32'(rd_valid), 32'd0);
      chk("rst_drop", 32'(wr_drop), 32'd0);
      @(posedge clk);
      #1;
      model_reset();
      check_all("rst_held");
      rst_n = 1'b1;
      count_busy("restart", n);
      chk("restart_busy_cycles", 32'(n), 32'd32);
      set_rd(0, 9, 1, 9);
      step("rd_after_restart");
      chk("gpr9_after_restart", ra_data, 32'h0);
      set_idle();

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         clr_req = ($urandom_range(0, 49) == 0);
         we      = $urandom_range(0, 1) != 0;
         wbank   = 1'($urandom_range(0, 1));
         waddr   = 5'($urandom_range(0, 7));
         wdata   = $urandom;
         re      = $urandom_range(0, 3) != 0;
         ra_bank = 1'($urandom_range(0, 1));
         ra_addr = 5'($urandom_range(0, 7));
         rb_bank = 1'($urandom_range(0, 1));
         rb_addr = 5'($urandom_range(0, 7));
         step("rnd");
      end
      set_idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
